// File: rtl/lsb_enum_pkg.sv
// ---------------------------------------------------------------------------
// lsb_enum_pkg
// Shared definitions for the set-bit enumerator slice.
//   WIDTH_DEFAULT : default width of the loaded word
//   state_t       : FSM state encoding (IDLE, SCAN, DONE)
// ---------------------------------------------------------------------------
package lsb_enum_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lsb_pri_enc.sv
// ---------------------------------------------------------------------------
// lsb_pri_enc
// Combinational priority encoder: returns the index of the lowest set bit
// of word. An all-zero word encodes as index 0; the caller decides whether
// the index is meaningful.
// Ports:
//   word : input  [WIDTH-1:0] word to encode
//   idx  : output [IDX_W-1:0] index of the lowest set bit
// ---------------------------------------------------------------------------
module lsb_pri_enc
  import lsb_enum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (word[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/lsb_enum.sv
// ---------------------------------------------------------------------------
// lsb_enum
// Enumerates the set bits of a loaded word in ascending index order, one
// index per accepted valid/ready beat, then pulses done for one cycle.
// Ports:
//   clk       : input  clock, rising edge
//   rst_n     : input  asynchronous active-low reset
//   load      : input  capture in1 on this edge (overrides any transfer)
//   in1       : input  [WIDTH-1:0] word to enumerate
//   out_valid : output out_idx holds a valid index (state SCAN)
//   out_ready : input  consumer accepts out_idx
//   out_idx   : output [IDX_W-1:0] lowest set bit of remaining (0 outside SCAN)
//   remaining : output [WIDTH-1:0] working word, accepted bits removed
//   busy      : output high in SCAN
//   done      : output one-cycle pulse after the last bit is accepted
//   count     : output [IDX_W:0] beats transferred since the last load
//               (only when LSB_ENUM_COUNT_EN is defined)
// Configuration macro: LSB_ENUM_COUNT_EN
// ---------------------------------------------------------------------------
module lsb_enum
  import lsb_enum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
`ifdef LSB_ENUM_COUNT_EN
  output logic             done,
  output logic [IDX_W:0]   count
`else
  output logic             done
`endif
);

  state_t           state;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_cleared;
  logic [IDX_W-1:0] low_idx;
  logic             beat;

  lsb_pri_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_pri_enc (
    .word (rem_q),
    .idx  (low_idx)
  );

  // Dropping the lowest set bit: x & (x - 1) clears exactly that bit.
  assign rem_cleared = rem_q & (rem_q - WIDTH'(1));
  assign beat        = out_valid & out_ready;

  // Status outputs are pure decodes of the state register, so they change
  // only on the clock edge (or immediately on reset).
  assign out_valid = (state == SCAN);
  assign busy      = (state == SCAN);
  assign done      = (state == DONE);
  assign out_idx   = (state == SCAN) ? low_idx : '0;
  assign remaining = rem_q;

  // FSM and working word. A load wins over any simultaneous transfer, so
  // the in-flight index is discarded and enumeration restarts from in1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem_q <= '0;
    end else if (load) begin
      rem_q <= in1;
      state <= (in1 != '0) ? SCAN : DONE;
    end else begin
      case (state)
        SCAN: begin
          if (out_ready) begin
            rem_q <= rem_cleared;
            if (rem_cleared == '0) begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        IDLE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSB_ENUM_COUNT_EN
  // Beat counter: restarts on each load and holds through DONE/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (beat) begin
      count <= count + 1'b1;
    end
  end
`else
  // Beat detection only feeds the optional counter.
  logic unused_beat;
  assign unused_beat = beat;
`endif

endmodule

// File: tb/tb_lsb_enum.sv
// ---------------------------------------------------------------------------
// tb_lsb_enum
// Self-checking bench for lsb_enum: directed vector table, hand-written
// reset/restart sequences and a randomized run against a queue-based model.
// Honours LSB_ENUM_COUNT_EN for the optional count port.
// ---------------------------------------------------------------------------
module tb_lsb_enum;

  localparam int WIDTH = 32;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] in1;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [WIDTH-1:0] remaining;
  logic             busy;
  logic             done;
`ifdef LSB_ENUM_COUNT_EN
  logic [IDX_W:0]   count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: pending indices in ascending order, plus phase
  // (0 = idle, 1 = emitting, 2 = done pulse) and a beat counter.
  int mq[$];
  int mphase;
  int mcount;

  typedef struct {
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             rdy;
    logic             ev;
    logic [IDX_W-1:0] eidx;
    logic             chk_idx;
    logic [WIDTH-1:0] erem;
    logic             edone;
  } vec_t;

  vec_t vecs[$];

  lsb_enum #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .remaining (remaining),
    .busy      (busy),
`ifdef LSB_ENUM_COUNT_EN
    .done      (done),
    .count     (count)
`else
    .done      (done)
`endif
  );

  always #5 clk = ~clk;

  // Drive inputs at a falling edge and return at the next falling edge.
  task automatic applyStimulus(input logic l, input logic [WIDTH-1:0] d, input logic r);
    load      = l;
    in1       = d;
    out_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [IDX_W-1:0] eidx,
                             input logic chk_idx, input logic [WIDTH-1:0] erem, input logic edone);
    n_tests++;
    if (out_valid !== ev) begin
      n_fail++;
      $display("[TB] FAIL %s out_valid got %0b want %0b", tag, out_valid, ev);
    end
    n_tests++;
    if (busy !== ev) begin
      n_fail++;
      $display("[TB] FAIL %s busy got %0b want %0b", tag, busy, ev);
    end
    n_tests++;
    if (done !== edone) begin
      n_fail++;
      $display("[TB] FAIL %s done got %0b want %0b", tag, done, edone);
    end
    n_tests++;
    if (remaining !== erem) begin
      n_fail++;
      $display("[TB] FAIL %s remaining got %h want %h", tag, remaining, erem);
    end
    if (chk_idx) begin
      n_tests++;
      if (out_idx !== eidx) begin
        n_fail++;
        $display("[TB] FAIL %s out_idx got %0d want %0d", tag, out_idx, eidx);
      end
    end
  endtask

  task automatic checkCount(input string tag, input int ecount);
`ifdef LSB_ENUM_COUNT_EN
    n_tests++;
    if (count !== (IDX_W + 1)'(ecount)) begin
      n_fail++;
      $display("[TB] FAIL %s count got %0d want %0d", tag, count, ecount);
    end
`else
    if (tag.len() < 0 || ecount < 0) $display("[TB] note %s", tag);
`endif
  endtask

  task automatic modelReset();
    mq.delete();
    mphase = 0;
    mcount = 0;
  endtask

  task automatic modelStep(input logic l, input logic [WIDTH-1:0] d, input logic r);
    if (l) begin
      mq.delete();
      for (int i = 0; i < WIDTH; i++) begin
        if (d[i]) mq.push_back(i);
      end
      mphase = (mq.size() != 0) ? 1 : 2;
      mcount = 0;
    end else if (mphase == 1) begin
      if (r) begin
        void'(mq.pop_front());
        mcount++;
        if (mq.size() == 0) mphase = 2;
      end
    end else if (mphase == 2) begin
      mphase = 0;
    end
  endtask

  function automatic logic [WIDTH-1:0] modelRem();
    logic [WIDTH-1:0] r;
    r = '0;
    foreach (mq[k]) r[mq[k]] = 1'b1;
    return r;
  endfunction

  task automatic doReset();
    rst_n     = 1'b0;
    load      = 1'b0;
    out_ready = 1'b0;
    in1       = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] d;
    logic             l;
    logic             r;
    ones = '1;

    // Reset state.
    rst_n     = 1'b0;
    load      = 1'b0;
    in1       = '0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("reset", 1'b0, '0, 1'b1, '0, 1'b0);
    checkCount("reset", 0);
    rst_n = 1'b1;

    // ld, in1, rdy -> valid, idx, chk_idx, remaining, done (after the edge)
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  1'b1, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h8000_0001, 1'b1, 1'b1, 5'd0,  1'b1, 32'h8000_0001, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b1, 5'd31, 1'b1, 32'h8000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b1, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_000A, 1'b1, 1'b1, 5'd1,  1'b1, 32'h0000_000A, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b1, 5'd3,  1'b1, 32'h0000_0008, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b0, 1'b1, 5'd3,  1'b1, 32'h0000_0008, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b1, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_00F0, 1'b0, 1'b1, 5'd4,  1'b1, 32'h0000_00F0, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b1, 5'd5,  1'b1, 32'h0000_00E0, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0003, 1'b1, 1'b1, 5'd0,  1'b1, 32'h0000_0003, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b1, 5'd1,  1'b1, 32'h0000_0002, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b1, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0004, 1'b1, 1'b1, 5'd2,  1'b1, 32'h0000_0004, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b1, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b1, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0000_0000, 1'b0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ld, vecs[i].d, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eidx, vecs[i].chk_idx,
                  vecs[i].erem, vecs[i].edone);
    end

    // Reset in the middle of a scan abandons the word with no done pulse.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("five_beats", 1'b1, 5'd5, 1'b1, 32'hFFFF_FFE0, 1'b0);
    checkCount("five_beats", 5);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 1'b0, '0, 1'b1, '0, 1'b0);
    checkCount("async_reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput($sformatf("post_reset%0d", k), 1'b0, '0, 1'b0, '0, 1'b0);
    end

    // Full word: 32 beats in ascending order, done after the last one.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
    checkOutput("full_0", 1'b1, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    for (int k = 1; k < 32; k++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput($sformatf("full_%0d", k), 1'b1, IDX_W'(k), 1'b1, ones << k, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("full_done", 1'b0, '0, 1'b1, '0, 1'b1);
    checkCount("full_done", 32);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("full_idle", 1'b0, '0, 1'b0, '0, 1'b0);
    checkCount("full_idle", 32);

    // Randomized run against the model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      l = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = $urandom;
        2:       d = $urandom & $urandom & $urandom;
        default: d = (ones >> $urandom_range(0, 31)) & (ones << $urandom_range(0, 31));
      endcase
      r = ($urandom_range(0, 9) < 6);
      applyStimulus(l, d, r);
      modelStep(l, d, r);
      checkOutput($sformatf("rand%0d", c), mphase == 1,
                  (mphase == 1) ? IDX_W'(mq[0]) : '0, mphase != 0, modelRem(), mphase == 2);
      checkCount($sformatf("rand%0d", c), mcount);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
